// File: rtl/hex_scroller_if.sv
// Control/status bundle between hex_scroller and the logic that loads and steers it.
// Honours HEX_SCROLL_GAP_EN so the pos width tracks the scroll period.
interface hex_scroller_if #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 8,
  parameter int GAP_LEN    = 2
);
`ifdef HEX_SCROLL_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int PERIOD = MSG_LEN + (GAP_EN ? GAP_LEN : 0);
  localparam int POS_W  = $clog2(PERIOD);
  localparam int ADDR_W = $clog2(MSG_LEN);

  logic                    enable;
  logic                    pause;
  logic                    dir;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [4:0]              wr_data;
  logic [7*NUM_DIGITS-1:0] hex;
  logic [POS_W-1:0]        pos;
  logic                    wrap;

  modport slave (
    input  enable, pause, dir, wr_en, wr_addr, wr_data,
    output hex, pos, wrap
  );

  modport master (
    output enable, pause, dir, wr_en, wr_addr, wr_data,
    input  hex, pos, wrap
  );
endinterface

// File: rtl/hex_scroller.sv
// Scrolling seven-segment text engine: message buffer, window decode, rate-controlled stepping.
// Optional HEX_SCROLL_GAP_EN appends GAP_LEN blank characters to each scroll period.
module hex_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN    = 8,
  parameter int CLK_HZ     = 50000000,
  parameter int STEP_HZ    = 2,
  parameter int GAP_LEN    = 2
) (
  input  logic           CLOCK50,
  input  logic           reset,
  hex_scroller_if.slave  bus
);
`ifdef HEX_SCROLL_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int PERIOD  = MSG_LEN + (GAP_EN ? GAP_LEN : 0);
  localparam int POS_W   = $clog2(PERIOD);
  localparam int ADDR_W  = $clog2(MSG_LEN);
  localparam int DIV     = CLK_HZ / STEP_HZ;
  localparam int PRESC_W = $clog2(DIV);
  localparam int HEX_W   = 7 * NUM_DIGITS;

  // Active-low glyphs, bit0 = segment a .. bit6 = segment g.
  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    logic [6:0] seg;
    case (code)
      5'd0:    seg = 7'h40;
      5'd1:    seg = 7'h79;
      5'd2:    seg = 7'h24;
      5'd3:    seg = 7'h30;
      5'd4:    seg = 7'h19;
      5'd5:    seg = 7'h12;
      5'd6:    seg = 7'h02;
      5'd7:    seg = 7'h78;
      5'd8:    seg = 7'h00;
      5'd9:    seg = 7'h10;
      5'd10:   seg = 7'h08;
      5'd11:   seg = 7'h03;
      5'd12:   seg = 7'h46;
      5'd13:   seg = 7'h21;
      5'd14:   seg = 7'h06;
      5'd15:   seg = 7'h0E;
      5'd17:   seg = 7'h0C;
      5'd18:   seg = 7'h11;
      5'd19:   seg = 7'h2B;
      5'd20:   seg = 7'h41;
      5'd21:   seg = 7'h47;
      5'd22:   seg = 7'h09;
      5'd23:   seg = 7'h2F;
      5'd24:   seg = 7'h23;
      5'd25:   seg = 7'h3F;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [4:0]         msg_q [MSG_LEN];
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               wrap_q, wrap_d;
  logic [HEX_W-1:0]   hex_q, hex_d;
  logic               step;
  logic               wr_ok;

  // Step decision, next position/wrap and prescaler next state.
  always_comb begin
    step    = bus.enable && !bus.pause && (presc_q == PRESC_W'(DIV - 1));
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    presc_d = {PRESC_W{1'b0}};
    if (bus.enable && (presc_q != PRESC_W'(DIV - 1))) begin
      presc_d = presc_q + PRESC_W'(1);
    end else begin
      presc_d = {PRESC_W{1'b0}};
    end
    if (step && !bus.dir) begin
      wrap_d = (pos_q == POS_W'(PERIOD - 1));
      pos_d  = wrap_d ? {POS_W{1'b0}} : pos_q + POS_W'(1);
    end else if (step && bus.dir) begin
      wrap_d = (pos_q == {POS_W{1'b0}});
      pos_d  = wrap_d ? POS_W'(PERIOD - 1) : pos_q - POS_W'(1);
    end else begin
      pos_d  = pos_q;
      wrap_d = 1'b0;
    end
    // Widened by one bit so the range test stays meaningful for power-of-two depths.
    wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(MSG_LEN));
  end

  // Window decode; virtual indices past the message read as blank.
  always_comb begin
    logic [31:0] vidx;
    logic [4:0]  ch;
    hex_d = {HEX_W{1'b1}};
    vidx  = 32'd0;
    ch    = 5'd16;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      vidx = (32'(pos_q) + 32'(NUM_DIGITS - 1 - k)) % 32'(PERIOD);
      if (vidx < 32'(MSG_LEN)) begin
        ch = msg_q[vidx[ADDR_W-1:0]];
      end else begin
        ch = 5'd16;
      end
      hex_d[7*k +: 7] = seg_decode(ch);
    end
  end

  // All architectural state: buffer, prescaler, position, wrap pulse, display register.
  always_ff @(posedge CLOCK50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_q[i] <= 5'd16;
      end
      presc_q <= {PRESC_W{1'b0}};
      pos_q   <= {POS_W{1'b0}};
      wrap_q  <= 1'b0;
      hex_q   <= {HEX_W{1'b1}};
    end else begin
      if (wr_ok) begin
        msg_q[bus.wr_addr] <= bus.wr_data;
      end
      presc_q <= presc_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
    end
  end

  assign bus.hex  = hex_q;
  assign bus.pos  = pos_q;
  assign bus.wrap = wrap_q;
endmodule
